// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between two requesters, the shared immediate extender and its consumer.
// No storage here; timing is set entirely by the arbiter.
// The arbiter returns per-requester req_ready and takes out_ready from the consumer.
interface imm_ext_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_mode0;
  logic [1:0]  req_mode1;
  logic [7:0]  req_data0;
  logic [7:0]  req_data1;
  logic [1:0]  req_ready;
  logic [15:0] result;
  logic        result_valid;
  logic        result_id;
  logic        out_ready;
  logic        busy;

  // Requester/consumer side: drives requests and out_ready, observes grants and result.
  modport master (
    output req_valid, req_mode0, req_mode1, req_data0, req_data1, out_ready,
    input  req_ready, result, result_valid, result_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_mode0, req_mode1, req_data0, req_data1, out_ready,
    output req_ready, result, result_valid, result_id, busy
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one 8->16 bit immediate extender (zero/sign/high-byte/two-beat compose).
// Latency: one cycle from accepted beat to result_valid; compose first beat produces no output.
// Backpressure: beats that write the output wait for a free output slot; compose first beat never waits.
module imm_ext_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  imm_ext_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ZERO    = 2'b00;
  localparam logic [1:0] MODE_SIGN    = 2'b01;
  localparam logic [1:0] MODE_HIGH    = 2'b10;
  localparam logic [1:0] MODE_COMPOSE = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prio;
  logic        r_owner;
  logic [7:0]  r_lo;
  logic [15:0] r_result;
  logic        r_result_valid;
  logic        r_result_id;

  logic        w_slot_free;
  logic        w_winner;
  logic [1:0]  w_mode;
  logic [7:0]  w_data;
  logic [1:0]  w_ready;
  logic        w_compose_first;
  logic        w_load_result;
  logic [15:0] w_result_nxt;

  // The output register can take a new value if it is empty or being drained this cycle.
  assign w_slot_free = !r_result_valid || bus.out_ready;

  // Pick the candidate: the lock owner, else the sole valid requester, else the priority holder.
  always_comb begin
    w_winner = r_prio;
    if (r_state == ST_LOCK) begin
      w_winner = r_owner;
    end else begin
      case (bus.req_valid)
        2'b01:   w_winner = 1'b0;
        2'b10:   w_winner = 1'b1;
        default: w_winner = r_prio;
      endcase
    end
  end

  assign w_mode = w_winner ? bus.req_mode1 : bus.req_mode0;
  assign w_data = w_winner ? bus.req_data1 : bus.req_data0;

  // Next-state and grant decode; at most one requester is granted per cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready         = 2'b00;
    w_compose_first = 1'b0;
    w_load_result   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid[w_winner] && (w_mode == MODE_COMPOSE || w_slot_free)) begin
          w_ready[w_winner] = 1'b1;
          if (w_mode == MODE_COMPOSE) begin
            w_compose_first = 1'b1;
            w_state_nxt     = ST_LOCK;
          end else begin
            w_load_result = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        // Second beat's mode field is irrelevant: it always completes the compose.
        if (bus.req_valid[r_owner] && w_slot_free) begin
          w_ready[r_owner] = 1'b1;
          w_load_result    = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Extension datapath for the granted beat.
  always_comb begin
    w_result_nxt = {8'h00, w_data};
    if (r_state == ST_LOCK) begin
      w_result_nxt = {w_data, r_lo};
    end else begin
      case (w_mode)
        MODE_ZERO: w_result_nxt = {8'h00, w_data};
        MODE_SIGN: w_result_nxt = {{8{w_data[7]}}, w_data};
        MODE_HIGH: w_result_nxt = {w_data, 8'h00};
        default:   w_result_nxt = {8'h00, w_data};
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register, round-robin pointer and compose low-byte latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result       <= 16'h0000;
      r_result_valid <= 1'b0;
      r_result_id    <= 1'b0;
      r_prio         <= RESET_PRIO;
      r_owner        <= 1'b0;
      r_lo           <= 8'h00;
    end else begin
      if (w_load_result) begin
        r_result       <= w_result_nxt;
        r_result_valid <= 1'b1;
        r_result_id    <= w_winner;
        r_prio         <= ~w_winner;
      end else if (bus.out_ready) begin
        r_result_valid <= 1'b0;
      end
      if (w_compose_first) begin
        r_lo    <= w_data;
        r_owner <= w_winner;
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.result_id    = r_result_id;
  assign bus.busy         = (r_state == ST_LOCK);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: directed vectors, a reference model checked every cycle,
// and literal expectations at key points of each scenario.
module tb_imm_ext_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_ext_arbiter_if bus();

  imm_ext_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the outputs must hold.
  bit          m_init = 1'b0;
  bit          m_locked;
  bit          m_prio;
  bit          m_owner;
  bit          m_vld;
  bit          m_id;
  logic [7:0]  m_lo;
  logic [15:0] m_res;

  function automatic bit m_pick();
    if (bus.req_valid == 2'b11) return m_prio;
    return bus.req_valid[1];
  endfunction

  function automatic logic [1:0] m_ready();
    bit slot;
    bit w;
    logic [1:0] md;
    slot = !m_vld || bus.out_ready;
    if (m_locked) begin
      if (bus.req_valid[m_owner] && slot) return (m_owner ? 2'b10 : 2'b01);
      return 2'b00;
    end
    if (bus.req_valid == 2'b00) return 2'b00;
    w  = m_pick();
    md = w ? bus.req_mode1 : bus.req_mode0;
    if (md == 2'b11 || slot) return (w ? 2'b10 : 2'b01);
    return 2'b00;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] r;
    bit w;
    bit consume;
    logic [1:0] md;
    logic [7:0] d;
    if (reset) begin
      m_init   = 1'b1;
      m_locked = 1'b0;
      m_prio   = 1'b0;
      m_owner  = 1'b0;
      m_vld    = 1'b0;
      m_id     = 1'b0;
      m_lo     = 8'h00;
      m_res    = 16'h0000;
    end else if (m_init) begin
      r       = m_ready();
      consume = m_vld && bus.out_ready;
      w       = m_locked ? m_owner : m_pick();
      md      = w ? bus.req_mode1 : bus.req_mode0;
      d       = w ? bus.req_data1 : bus.req_data0;
      if (r == 2'b00) begin
        if (consume) m_vld = 1'b0;
      end else if (m_locked) begin
        m_res    = {d, m_lo};
        m_vld    = 1'b1;
        m_id     = w;
        m_prio   = !w;
        m_locked = 1'b0;
      end else if (md == 2'b11) begin
        m_lo     = d;
        m_owner  = w;
        m_locked = 1'b1;
        if (consume) m_vld = 1'b0;
      end else begin
        case (md)
          2'b00:   m_res = 16'(d);
          2'b01:   m_res = (d >= 8'h80) ? (16'hFF00 + 16'(d)) : 16'(d);
          default: m_res = 16'(d) * 16'd256;
        endcase
        m_vld  = 1'b1;
        m_id   = w;
        m_prio = !w;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("ready",        bus.req_ready,    m_ready());
      chk("ready_onehot", bus.req_ready == 2'b11, 1'b0);
      chk("result",       bus.result,       m_res);
      chk("result_valid", bus.result_valid, m_vld);
      chk("result_id",    bus.result_id,    m_id);
      chk("busy",         bus.busy,         m_locked);
    end
  end

  task automatic drive(input logic rst, input logic [1:0] v,
                       input logic [1:0] m0, input logic [7:0] d0,
                       input logic [1:0] m1, input logic [7:0] d1, input logic o);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req_valid = v;
    bus.req_mode0 = m0;
    bus.req_data0 = d0;
    bus.req_mode1 = m1;
    bus.req_data1 = d1;
    bus.out_ready = o;
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_mode0 = 2'b00;
    bus.req_mode1 = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    drive(1, 2'b00, 0, 8'h00, 0, 8'h00, 1);
    drive(1, 2'b00, 0, 8'h00, 0, 8'h00, 1);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_valid",  bus.result_valid, 1'b0);
    chk("rst_id",     bus.result_id, 1'b0);
    chk("rst_busy",   bus.busy, 1'b0);

    // Single zero-extend
    drive(0, 2'b01, 2'b00, 8'hFF, 2'b00, 8'h00, 1);
    chk("t1_ready", bus.req_ready, 2'b01);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t1_result", bus.result, 16'h00FF);
    chk("t1_valid",  bus.result_valid, 1'b1);
    chk("t1_id",     bus.result_id, 1'b0);

    // Round robin with both valid, starting from reset priority 0
    drive(1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    drive(0, 2'b11, 2'b01, 8'h80, 2'b10, 8'h12, 1);
    chk("t2_g0", bus.req_ready, 2'b01);
    drive(0, 2'b11, 2'b01, 8'h80, 2'b10, 8'h12, 1);
    chk("t2_g1", bus.req_ready, 2'b10);
    chk("t2_r0", bus.result, 16'hFF80);
    chk("t2_i0", bus.result_id, 1'b0);
    drive(0, 2'b11, 2'b01, 8'h80, 2'b10, 8'h12, 1);
    chk("t2_g2", bus.req_ready, 2'b01);
    chk("t2_r1", bus.result, 16'h1200);
    chk("t2_i1", bus.result_id, 1'b1);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t2_r2", bus.result, 16'hFF80);
    chk("t2_i2", bus.result_id, 1'b0);

    // Requester 1 compose while requester 0 keeps asking
    drive(0, 2'b11, 2'b00, 8'h07, 2'b11, 8'h34, 1);
    chk("t3_first", bus.req_ready, 2'b10);
    drive(0, 2'b11, 2'b00, 8'h07, 2'b00, 8'hAB, 1);
    chk("t3_busy",   bus.busy, 1'b1);
    chk("t3_second", bus.req_ready, 2'b10);
    drive(0, 2'b01, 2'b00, 8'h07, 2'b00, 8'h00, 1);
    chk("t3_r0grant", bus.req_ready, 2'b01);
    chk("t3_result",  bus.result, 16'hAB34);
    chk("t3_id",      bus.result_id, 1'b1);
    chk("t3_unbusy",  bus.busy, 1'b0);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t3_next", bus.result, 16'h0007);

    // Output stall
    drive(0, 2'b01, 2'b00, 8'h11, 2'b00, 8'h00, 0);
    chk("t4_acc", bus.req_ready, 2'b01);
    drive(0, 2'b01, 2'b00, 8'h22, 2'b00, 8'h00, 0);
    chk("t4_stall_rdy", bus.req_ready, 2'b00);
    chk("t4_stall_res", bus.result, 16'h0011);
    drive(0, 2'b01, 2'b00, 8'h22, 2'b00, 8'h00, 0);
    chk("t4_hold_rdy", bus.req_ready, 2'b00);
    chk("t4_hold_res", bus.result, 16'h0011);
    chk("t4_hold_vld", bus.result_valid, 1'b1);
    drive(0, 2'b01, 2'b00, 8'h22, 2'b00, 8'h00, 1);
    chk("t4_release", bus.req_ready, 2'b01);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 0);
    chk("t4_b2b_res", bus.result, 16'h0022);
    chk("t4_b2b_vld", bus.result_valid, 1'b1);

    // Compose first beat while output is stalled
    drive(0, 2'b01, 2'b11, 8'hCD, 2'b00, 8'h00, 0);
    chk("t5_first", bus.req_ready, 2'b01);
    drive(0, 2'b01, 2'b00, 8'hEF, 2'b00, 8'h00, 0);
    chk("t5_busy",  bus.busy, 1'b1);
    chk("t5_wait",  bus.req_ready, 2'b00);
    chk("t5_hold",  bus.result, 16'h0022);
    drive(0, 2'b01, 2'b00, 8'hEF, 2'b00, 8'h00, 1);
    chk("t5_second", bus.req_ready, 2'b01);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t5_result", bus.result, 16'hEFCD);
    chk("t5_id",     bus.result_id, 1'b0);

    // Reset while locked
    drive(0, 2'b01, 2'b11, 8'h55, 2'b00, 8'h00, 1);
    chk("t6_first", bus.req_ready, 2'b01);
    drive(1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t6_locked", bus.busy, 1'b1);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_vld",  bus.result_valid, 1'b0);
    drive(0, 2'b01, 2'b00, 8'h01, 2'b00, 8'h00, 1);
    chk("t6_acc", bus.req_ready, 2'b01);
    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    chk("t6_result", bus.result, 16'h0001);
    chk("t6_valid",  bus.result_valid, 1'b1);

    drive(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
